// File: rtl/wm_sync_sink.sv
// Credit-returning sink behind a two-input wait-merge stage: buffers merged
// bundles in a FWFT FIFO, splits them into their source fields, returns frees.
module wm_sync_sink #(
  parameter int unsigned DATA_WIDTH_I0 = 18,
  parameter int unsigned DATA_WIDTH_I1 = 32,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_drive,
  input  logic [DATA_WIDTH_I0+DATA_WIDTH_I1-1:0] i_data,
  output logic                                   o_free,
  output logic                                   o_valid,
  output logic [DATA_WIDTH_I0-1:0]               o_data0,
  output logic [DATA_WIDTH_I1-1:0]               o_data1,
  input  logic                                   i_ready,
  output logic [$clog2(DEPTH):0]                 o_count,
  output logic                                   o_err
);

  localparam int unsigned DW = DATA_WIDTH_I0 + DATA_WIDTH_I1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_FREE  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic            free_q, free_d;
  logic            err_q, err_d;
  logic [DW-1:0]   head_q, head_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic            push;
  logic            pop;

  // Only the credit holder's drive is accepted; anything else is dropped.
  assign push = (state_q == S_READY) & i_drive;
  assign pop  = valid_q & i_ready;

  // Next-state, pointer, occupancy and registered-head computation.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    valid_d  = (count_d != '0);
    err_d    = err_q | (i_drive & (state_q != S_READY));
    head_d   = head_q;

    // The new head is the bundle being written when the write slot becomes rd_ptr.
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = i_data;
    end else if (count_d != '0) begin
      head_d = mem_q[rd_ptr_d];
    end

    unique case (state_q)
      S_READY: begin
        if (push) begin
          state_d = (count_d < CW'(DEPTH)) ? S_FREE : S_HOLD;
        end
      end
      S_FREE:  state_d = S_READY;
      S_HOLD: begin
        if (pop) begin
          state_d = S_FREE;
        end
      end
      default: state_d = S_READY;
    endcase

    free_d = (state_d == S_FREE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_READY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      free_q   <= 1'b0;
      err_q    <= 1'b0;
      head_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      free_q   <= free_d;
      err_q    <= err_d;
      head_q   <= head_d;
    end
  end

  // Storage array needs no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_free  = free_q;
  assign o_valid = valid_q;
  assign o_count = count_q;
  assign o_err   = err_q;
  assign o_data0 = head_q[DATA_WIDTH_I0-1:0];
  assign o_data1 = head_q[DW-1:DATA_WIDTH_I0];

endmodule
